iob_ram_sp_ctrl: RTL and testbench

Initiator-side controller that drives the enable/write/address/data port of a single-port synchronous RAM (1-cycle registered read, output register holds between reads and is not updated by writes). Presents a valid/ready request channel and a valid/ready response channel to a client such as a cache datapath. Includes a fill sequencer that writes a constant to every RAM word, for cache/tag invalidation at boot or on flush.

---
 rtl/iob_ram_sp_ctrl_if.sv | 39 +++
 rtl/iob_ram_sp_ctrl.sv | 134 +++++++++++++
 tb/tb_iob_ram_sp_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/iob_ram_sp_ctrl_if.sv
// ----------------------------------------------------------------------------
// iob_ram_sp_ctrl_if
// Client-side request/response channels of the single-port RAM controller.
//
// Signals:
//   req_valid  client -> ctrl  request valid
//   req_we     client -> ctrl  1 = write, 0 = read
//   req_addr   client -> ctrl  request address (ADDR_W)
//   req_wdata  client -> ctrl  write data (DATA_W)
//   req_ready  ctrl -> client  request accepted when req_valid & req_ready
//   rsp_valid  ctrl -> client  read data valid
//   rsp_rdata  ctrl -> client  read data (DATA_W)
//   rsp_ready  client -> ctrl  client accepts response
//
// Modports: master = client (cache datapath), slave = controller.
// ----------------------------------------------------------------------------
interface iob_ram_sp_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_ready;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/iob_ram_sp_ctrl.sv
// ----------------------------------------------------------------------------
// iob_ram_sp_ctrl
// Initiator-side controller for a single-port synchronous RAM with a 1-cycle
// registered read. Serves client reads/writes over a valid/ready request
// channel and a valid/ready response channel, and contains a fill sequencer
// that writes a constant to every RAM word (cache/tag invalidation).
//
// Ports:
//   clk_i         clock, rising edge
//   rst_i         synchronous active-high reset
//   init_start_i  start a fill of the whole RAM with init_val_i
//   init_val_i    fill value, captured when the fill starts
//   init_busy_o   high while the fill is running
//   init_done_o   one-cycle pulse after the last fill write
//   bus           request/response channels (slave side)
//   ram_en_o      RAM enable
//   ram_we_o      RAM write enable
//   ram_addr_o    RAM address
//   ram_d_o       RAM write data
//   ram_d_i       RAM read data (output register of the RAM)
//
// State | meaning
// ------+--------------------------------------------------------------
// IDLE  | serve client requests; accept a fill start
// FILL  | one fill write per cycle, address = counter, data = fill value
// ----------------------------------------------------------------------------
module iob_ram_sp_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 init_start_i,
    input  logic [DATA_W-1:0]    init_val_i,
    output logic                 init_busy_o,
    output logic                 init_done_o,
    iob_ram_sp_ctrl_if.slave     bus,
    output logic                 ram_en_o,
    output logic                 ram_we_o,
    output logic [ADDR_W-1:0]    ram_addr_o,
    output logic [DATA_W-1:0]    ram_d_o,
    input  logic [DATA_W-1:0]    ram_d_i
);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q;
    logic [DATA_W-1:0] fill_val_q;
    logic              done_q;
    logic              rsp_valid_q;
    logic              rsp_stall;
    logic              req_ready;
    logic              req_fire;
    logic              fill_last;

    // A pending response the client has not taken blocks every new request,
    // so the RAM output register (our read data) cannot be overwritten.
    assign rsp_stall = rsp_valid_q & ~bus.rsp_ready;
    assign req_ready = (state_q == IDLE) & ~init_start_i & ~rsp_stall;
    assign req_fire  = bus.req_valid & req_ready;
    assign fill_last = (state_q == FILL) && (cnt_q == LAST_ADDR);

    always_comb begin
        state_d    = state_q;
        ram_en_o   = 1'b0;
        ram_we_o   = 1'b0;
        ram_addr_o = '0;
        ram_d_o    = '0;
        unique case (state_q)
            IDLE: begin
                if (init_start_i) begin
                    state_d = FILL;
                end else if (req_fire) begin
                    ram_en_o   = 1'b1;
                    ram_we_o   = bus.req_we;
                    ram_addr_o = bus.req_addr;
                    ram_d_o    = bus.req_wdata;
                end
            end
            FILL: begin
                ram_en_o   = 1'b1;
                ram_we_o   = 1'b1;
                ram_addr_o = cnt_q;
                ram_d_o    = fill_val_q;
                if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            fill_val_q  <= '0;
            done_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= fill_last;

            if ((state_q == IDLE) && init_start_i) begin
                fill_val_q <= init_val_i;
                cnt_q      <= '0;
            end else if (state_q == FILL) begin
                // Park at 0 after the last word instead of relying on wrap.
                cnt_q <= fill_last ? '0 : cnt_q + ADDR_W'(1);
            end

            // A read accepted in the same cycle the old response is taken
            // keeps valid high: one read per cycle at full throughput.
            if (req_fire && !bus.req_we) begin
                rsp_valid_q <= 1'b1;
            end else if (bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = ram_d_i;
    assign init_busy_o   = (state_q == FILL);
    assign init_done_o   = done_q;

endmodule

// File: tb/tb_iob_ram_sp_ctrl.sv
module tb_iob_ram_sp_ctrl;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 2**ADDR_W;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              init_start_i;
    logic [DATA_W-1:0] init_val_i;
    logic              init_busy_o;
    logic              init_done_o;
    logic              ram_en_o;
    logic              ram_we_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [DATA_W-1:0] ram_d_o;
    logic [DATA_W-1:0] ram_d_i;

    iob_ram_sp_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    iob_ram_sp_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .init_start_i (init_start_i),
        .init_val_i   (init_val_i),
        .init_busy_o  (init_busy_o),
        .init_done_o  (init_done_o),
        .bus          (bus),
        .ram_en_o     (ram_en_o),
        .ram_we_o     (ram_we_o),
        .ram_addr_o   (ram_addr_o),
        .ram_d_o      (ram_d_o),
        .ram_d_i      (ram_d_i)
    );

    always #5 clk_i = ~clk_i;

    // single-port RAM: registered read, output register untouched by writes
    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge clk_i) begin
        if (ram_en_o) begin
            if (ram_we_o) mem[ram_addr_o] <= ram_d_o;
            else          ram_d_i <= mem[ram_addr_o];
        end
    end

    int n_cmp = 0;
    int n_err = 0;
    logic [DATA_W-1:0] exp_mem [DEPTH];
    logic [DATA_W-1:0] sb [$];
    logic mon_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk_i);
        #1;
    endtask

    // call at posedge+1; returns at posedge+1 after the accepting edge
    task automatic do_req(input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wd, output int waits);
        logic acc;
        acc = 1'b0;
        waits = 0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        while (!acc && waits < 100) begin
            @(negedge clk_i);
            if (bus.req_ready) acc = 1'b1;
            else               waits++;
            @(posedge clk_i);
            #1;
        end
        bus.req_valid = 1'b0;
        chk("req_accept", {31'd0, acc}, 32'd1);
        if (acc) begin
            if (we) exp_mem[addr] = wd;
            else    sb.push_back(exp_mem[addr]);
        end
    endtask

    // response monitor: valid must track the outstanding-read scoreboard
    always @(negedge clk_i) begin
        if (mon_en) begin
            chk("rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, sb.size() != 0});
            if (bus.rsp_valid && bus.rsp_ready && sb.size() != 0)
                chk("rsp_rdata", bus.rsp_rdata, sb.pop_front());
        end
    end

    initial begin
        int w;
        logic acc;
        logic done_at_acc;
        logic [ADDR_W-1:0] rd_a [3];

        rst_i = 1'b1;
        init_start_i = 1'b0;
        init_val_i = '0;
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        mon_en = 1'b1;

        @(negedge clk_i);
        chk("rst_busy", {31'd0, init_busy_o}, 32'd0);
        chk("rst_done", {31'd0, init_done_o}, 32'd0);
        chk("rst_ram_en", {31'd0, ram_en_o}, 32'd0);
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);

        // full fill with A5
        sync();
        init_start_i = 1'b1;
        init_val_i = 32'hA5A5A5A5;
        sync();
        init_start_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk_i);
            chk("fill_busy", {31'd0, init_busy_o}, 32'd1);
            chk("fill_en_we", {30'd0, ram_en_o, ram_we_o}, 32'd3);
            chk("fill_addr", {28'd0, ram_addr_o}, i);
            chk("fill_data", ram_d_o, 32'hA5A5A5A5);
            chk("fill_no_done", {31'd0, init_done_o}, 32'd0);
        end
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = 32'hA5A5A5A5;
        @(negedge clk_i);
        chk("fill_end_busy", {31'd0, init_busy_o}, 32'd0);
        chk("fill_done_pulse", {31'd0, init_done_o}, 32'd1);
        @(negedge clk_i);
        chk("fill_done_once", {31'd0, init_done_o}, 32'd0);

        sync();
        rd_a[0] = 4'd0; rd_a[1] = 4'd7; rd_a[2] = 4'd15;
        for (int i = 0; i < 3; i++) do_req(1'b0, rd_a[i], '0, w);
        sync(); sync();

        // write then read on the next cycle
        do_req(1'b1, 4'd3, 32'h12345678, w);
        do_req(1'b0, 4'd3, '0, w);
        chk("wr_rd_wait", w, 32'd0);
        sync(); sync();

        // back-to-back reads at full throughput
        do_req(1'b1, 4'd1, 32'h11, w);
        do_req(1'b1, 4'd2, 32'h22, w);
        do_req(1'b1, 4'd3, 32'h33, w);
        for (int i = 1; i <= 3; i++) begin
            do_req(1'b0, i[ADDR_W-1:0], '0, w);
            chk("b2b_wait", w, 32'd0);
        end
        sync(); sync();

        // response stall blocks a pending write
        bus.rsp_ready = 1'b0;
        do_req(1'b0, 4'd2, '0, w);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 4'd9;
        bus.req_wdata = 32'h99;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("stall_ready", {31'd0, bus.req_ready}, 32'd0);
            chk("stall_ram_en", {31'd0, ram_en_o}, 32'd0);
            chk("stall_rdata", bus.rsp_rdata, 32'h22);
            @(posedge clk_i);
            #1;
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk_i);
        chk("unstall_ready", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk_i);
        #1;
        bus.req_valid = 1'b0;
        exp_mem[9] = 32'h99;
        do_req(1'b0, 4'd9, '0, w);
        sync(); sync();

        // fill start wins over a same-cycle write
        init_start_i  = 1'b1;
        init_val_i    = 32'h5A5A5A5A;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 4'd5;
        bus.req_wdata = 32'hDEAD0005;
        acc = 1'b0;
        done_at_acc = 1'b0;
        w = 0;
        while (!acc && w < 100) begin
            @(negedge clk_i);
            if (bus.req_ready) begin
                acc = 1'b1;
                done_at_acc = init_done_o;
            end else begin
                w++;
            end
            @(posedge clk_i);
            #1;
            init_start_i = 1'b0;
        end
        bus.req_valid = 1'b0;
        chk("coll_accept", {31'd0, acc}, 32'd1);
        chk("coll_wait", w, 32'd17);
        chk("coll_done_at_acc", {31'd0, done_at_acc}, 32'd1);
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = 32'h5A5A5A5A;
        exp_mem[5] = 32'hDEAD0005;
        do_req(1'b0, 4'd5, '0, w);
        do_req(1'b0, 4'd4, '0, w);
        do_req(1'b0, 4'd15, '0, w);
        sync(); sync();

        // reset in the middle of a fill
        init_start_i = 1'b1;
        init_val_i = 32'hC3C3C3C3;
        sync();
        init_start_i = 1'b0;
        repeat (6) sync();
        @(negedge clk_i);
        chk("abort_addr", {28'd0, ram_addr_o}, 32'd6);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk("abort_busy", {31'd0, init_busy_o}, 32'd0);
        chk("abort_done", {31'd0, init_done_o}, 32'd0);
        chk("abort_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("abort_ram_en", {31'd0, ram_en_o}, 32'd0);
        @(negedge clk_i);
        chk("abort_no_done", {31'd0, init_done_o}, 32'd0);
        for (int i = 0; i < 6; i++) exp_mem[i] = 32'hC3C3C3C3;
        sync();
        for (int i = 0; i < 6; i++) do_req(1'b0, i[ADDR_W-1:0], '0, w);
        do_req(1'b0, 4'd7, '0, w);
        sync(); sync();

        chk("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
